// File: rtl/exe_mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mem_stage_if
//  Purpose  : Bundles the ID/EXE inputs, the EXE/MEM register outputs and the
//             ex_busy stall of the execute stage into one interface.
//  Ports    : master - upstream side; drives e*, observes m* and ex_busy
//             slave  - execute stage; reads e*, drives m* and ex_busy
//  Params   : DATA_W datapath width, REG_W register-specifier width
//  Revision : 1.0  initial release
// ============================================================================
interface exe_mem_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  // ID/EXE side
  logic              ewreg;
  logic              em2reg;
  logic              ewmem;
  logic [3:0]        ealuc;
  logic              ealuimm;
  logic [REG_W-1:0]  edestReg;
  logic [DATA_W-1:0] eqa;
  logic [DATA_W-1:0] eqb;
  logic [DATA_W-1:0] eimm32;
  // EXE/MEM side
  logic              mwreg;
  logic              mm2reg;
  logic              mwmem;
  logic [REG_W-1:0]  mdestReg;
  logic [DATA_W-1:0] mr;
  logic [DATA_W-1:0] mqb;
  logic              ex_busy;

  modport master (
    output ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
    input  mwreg, mm2reg, mwmem, mdestReg, mr, mqb, ex_busy
  );

  modport slave (
    input  ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg, eqa, eqb, eimm32,
    output mwreg, mm2reg, mwmem, mdestReg, mr, mqb, ex_busy
  );
endinterface
`default_nettype wire

// File: rtl/exe_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mem_stage
//  Purpose  : Execute stage. Selects ALU operand B (eqb or eimm32), evaluates
//             the ALU and registers result plus pass-through controls into the
//             EXE/MEM pipeline register.
//  Ports    : clk  - pipeline clock (posedge)
//             rst  - asynchronous active-high reset
//             bus  - exe_mem_stage_if.slave (e* in, m* and ex_busy out)
//  Config   : EXE_MUL_EN - adds opcode 1000, a DATA_W-iteration shift-add
//             unsigned multiply (low word) that stalls upstream via ex_busy.
//  Revision : 1.0  initial release
// ============================================================================
module exe_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  wire logic      clk,
  input  wire logic      rst,
  exe_mem_stage_if.slave bus
);

  localparam logic [3:0] c_op_and = 4'b0000;
  localparam logic [3:0] c_op_or  = 4'b0001;
  localparam logic [3:0] c_op_add = 4'b0010;
  localparam logic [3:0] c_op_sub = 4'b0110;
  localparam logic [3:0] c_op_slt = 4'b0111;
  localparam logic [3:0] c_op_nor = 4'b1100;

  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_r;
  // w_bubble: the EXE/MEM register takes a bubble this edge
  // w_mul_done: this edge retires a multiply result instead of the ALU result
  logic              w_bubble;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_res;

  always_comb begin
    w_alu_b = bus.ealuimm ? bus.eimm32 : bus.eqb;
    w_alu_r = '0;
    case (bus.ealuc)
      c_op_and: w_alu_r = bus.eqa & w_alu_b;
      c_op_or:  w_alu_r = bus.eqa | w_alu_b;
      c_op_add: w_alu_r = bus.eqa + w_alu_b;
      c_op_sub: w_alu_r = bus.eqa - w_alu_b;
      c_op_nor: w_alu_r = ~(bus.eqa | w_alu_b);
      c_op_slt: w_alu_r[0] = ($signed(bus.eqa) < $signed(w_alu_b));
      default:  w_alu_r = '0;
    endcase
  end

`ifdef EXE_MUL_EN
  localparam logic [3:0]  c_op_mul = 4'b1000;
  localparam int          c_cnt_w  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_MUL    = 1'b1;

  logic [0:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic [DATA_W-1:0]  r_mul_a;   // multiplicand, shifted left each iteration
  logic [DATA_W-1:0]  r_mul_b;   // multiplier, shifted right each iteration
  logic [DATA_W-1:0]  r_acc;     // running low-word partial product
  logic               w_start;
  logic               w_last;

  always_comb begin
    w_start    = (r_state == S_IDLE) && (bus.ealuc == c_op_mul);
    w_last     = (r_state == S_MUL) && (r_cnt == c_cnt_w'(DATA_W - 1));
    w_mul_res  = r_acc + (r_mul_b[0] ? r_mul_a : '0);
    w_mul_done = w_last;
    w_bubble   = w_start || ((r_state == S_MUL) && !w_last);
    // Drops on the final iteration so upstream advances on the result edge
    bus.ex_busy = w_bubble;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_mul_a <= '0;
      r_mul_b <= '0;
      r_acc   <= '0;
    end else if (w_start) begin
      r_state <= S_MUL;
      r_cnt   <= '0;
      r_mul_a <= bus.eqa;
      r_mul_b <= w_alu_b;
      r_acc   <= '0;
    end else if (r_state == S_MUL) begin
      r_acc   <= w_mul_res;
      r_mul_a <= r_mul_a << 1;
      r_mul_b <= r_mul_b >> 1;
      r_cnt   <= r_cnt + c_cnt_w'(1);
      if (w_last) begin
        r_state <= S_IDLE;
      end
    end
  end
`else
  always_comb begin
    w_bubble    = 1'b0;
    w_mul_done  = 1'b0;
    w_mul_res   = '0;
    bus.ex_busy = 1'b0;
  end
`endif

  // EXE/MEM pipeline register. On the multiply result edge the controls come
  // from the ID/EXE inputs, which upstream has held stable during the stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mwreg    <= 1'b0;
      bus.mm2reg   <= 1'b0;
      bus.mwmem    <= 1'b0;
      bus.mdestReg <= '0;
      bus.mr       <= '0;
      bus.mqb      <= '0;
    end else if (w_bubble) begin
      bus.mwreg    <= 1'b0;
      bus.mm2reg   <= 1'b0;
      bus.mwmem    <= 1'b0;
      bus.mdestReg <= '0;
      bus.mr       <= '0;
      bus.mqb      <= '0;
    end else begin
      bus.mwreg    <= bus.ewreg;
      bus.mm2reg   <= bus.em2reg;
      bus.mwmem    <= bus.ewmem;
      bus.mdestReg <= bus.edestReg;
      bus.mr       <= w_mul_done ? w_mul_res : w_alu_r;
      bus.mqb      <= bus.eqb;
    end
  end

endmodule
`default_nettype wire
